dizy_stream_ctrl: RTL and testbench

- Keystream consumer and sequencer for the DIZY core. It drives the core's load/next/key interface and reads back its state.
- Runs the key/IV initialisation and warm-up rounds, then XORs extracted keystream words with an incoming plaintext stream to produce ciphertext.
- Sits between the cipher core, whether unrolled or iterative, and the system data path. It tolerates cores with non-zero busy latency.

---
 rtl/dizy_stream_ctrl_pkg.sv | 23 ++
 rtl/dizy_stream_ctrl.sv | 133 +++++++++++++
 tb/tb_dizy_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dizy_stream_ctrl_pkg.sv
// Shared definitions for DIZY keystream consumers: default sizes, sequencer
// state encoding and the keystream extraction slice.
package dizy_stream_ctrl_pkg;

    localparam int unsigned SIZE_STATE_DEF = 128;
    localparam int unsigned SIZE_KEY_DEF   = 128;
    localparam int unsigned SIZE_KS_DEF    = 32;
    localparam int unsigned N_WARMUP_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_KEY = 3'd1,
        ST_LOAD_IV  = 3'd2,
        ST_WARMUP   = 3'd3,
        ST_STREAM   = 3'd4
    } state_t;

    // Keystream word is taken from the MSBs of the core state.
    function automatic logic [SIZE_KS_DEF-1:0] ks_slice(input logic [SIZE_STATE_DEF-1:0] st);
        return st[SIZE_STATE_DEF-1 -: SIZE_KS_DEF];
    endfunction

endpackage

// File: rtl/dizy_stream_ctrl.sv
// DIZY keystream sequencer: key/IV load, warm-up rounds, then XOR of the
// plaintext stream with one fresh keystream word per accepted input.
module dizy_stream_ctrl
    import dizy_stream_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_STATE = SIZE_STATE_DEF,
    parameter int unsigned SIZE_KEY   = SIZE_KEY_DEF,
    parameter int unsigned SIZE_KS    = SIZE_KS_DEF,
    parameter int unsigned N_WARMUP   = N_WARMUP_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE_KEY-1:0]   key,
    input  logic [SIZE_KEY-1:0]   iv,
    output logic                  init_ready,
    input  logic [SIZE_KS-1:0]    s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [SIZE_KS-1:0]    m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  core_load,
    output logic                  core_next,
    output logic [SIZE_KEY-1:0]   core_key,
    input  logic                  core_busy,
    input  logic [SIZE_STATE-1:0] core_state
);

    localparam int unsigned CNT_W = (N_WARMUP > 1) ? $clog2(N_WARMUP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WARMUP - 1);

    state_t              state;
    logic [SIZE_KEY-1:0] key_r;
    logic [SIZE_KEY-1:0] iv_r;
    logic [CNT_W-1:0]    wcnt;
    logic [SIZE_KS-1:0]  ks;
    logic                start_acc;
    logic                fire;

    assign ks = core_state[SIZE_STATE-1 -: SIZE_KS];

    // Low state bits never feed the keystream.
    generate
        if (SIZE_STATE > SIZE_KS) begin : g_unused
            logic unused_state_bits;
            assign unused_state_bits = ^core_state[SIZE_STATE-SIZE_KS-1:0];
        end
    endgenerate

    // Handshakes and core strobes; everything is held quiet while in reset.
    always_comb begin
        init_ready = 1'b1;
        start_acc  = 1'b0;
        s_ready    = 1'b0;
        fire       = 1'b0;
        core_load  = 1'b0;
        core_next  = 1'b0;
        core_key   = '0;
        if (!rst) begin
            init_ready = (state == ST_IDLE) || ((state == ST_STREAM) && !m_valid);
            start_acc  = start && init_ready;
            s_ready    = (state == ST_STREAM) && !core_busy && (!m_valid || m_ready) && !start_acc;
            fire       = s_valid && s_ready;
            case (state)
                ST_LOAD_KEY: begin
                    if (!core_busy) begin
                        core_load = 1'b1;
                        core_key  = key_r;
                    end
                end
                ST_LOAD_IV: begin
                    if (!core_busy) begin
                        core_next = 1'b1;
                        core_key  = iv_r;
                    end
                end
                ST_WARMUP: core_next = !core_busy;
                ST_STREAM: core_next = fire;
                default:   core_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            key_r   <= '0;
            iv_r    <= '0;
            wcnt    <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (fire) begin
                m_data  <= s_data ^ ks;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_STREAM: begin
                    if (start_acc) begin
                        key_r <= key;
                        iv_r  <= iv;
                        state <= ST_LOAD_KEY;
                    end
                end
                ST_LOAD_KEY: begin
                    if (core_load) state <= ST_LOAD_IV;
                end
                ST_LOAD_IV: begin
                    if (core_next) begin
                        wcnt  <= '0;
                        state <= ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (core_next) begin
                        if (wcnt == CNT_LAST) begin
                            wcnt  <= '0;
                            state <= ST_STREAM;
                        end else begin
                            wcnt <= wcnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dizy_stream_ctrl.sv
// Directed bench for dizy_stream_ctrl with a behavioural core stub and an
// optional busy pattern (high two cycles out of three).
module tb_dizy_stream_ctrl;

    localparam int unsigned SS = 128;
    localparam int unsigned SK = 128;
    localparam int unsigned KS = 32;
    localparam int unsigned NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SK-1:0] key = '0;
    logic [SK-1:0] iv = '0;
    logic          init_ready;
    logic [KS-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [KS-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          core_load;
    logic          core_next;
    logic [SK-1:0] core_key;
    logic          core_busy;
    logic [SS-1:0] cst = '0;

    logic          busy_en = 1'b0;
    logic [1:0]    bcnt = 2'd0;
    int            n_load = 0;
    int            n_next = 0;
    int            n_busy_op = 0;
    int            total = 0;
    int            bad = 0;
    logic [SS-1:0] gst;

    always #5 clk = ~clk;

    dizy_stream_ctrl #(
        .SIZE_STATE(SS), .SIZE_KEY(SK), .SIZE_KS(KS), .N_WARMUP(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
        .init_ready(init_ready), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .core_load(core_load), .core_next(core_next),
        .core_key(core_key), .core_busy(core_busy), .core_state(cst)
    );

    function automatic logic [SS-1:0] f_load(input logic [SK-1:0] k);
        return k ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    function automatic logic [SS-1:0] f_next(input logic [SS-1:0] s, input logic [SK-1:0] k);
        return ({s[114:0], s[127:115]} ^ k) + (s >> 5) + 128'd1;
    endfunction

    function automatic logic [KS-1:0] f_ks(input logic [SS-1:0] s);
        return s[127:96];
    endfunction

    assign core_busy = busy_en && (bcnt != 2'd0);

    // Core stub plus operation monitor.
    always @(posedge clk) begin
        bcnt <= (bcnt == 2'd2) ? 2'd0 : bcnt + 2'd1;
        if (core_load) cst <= f_load(core_key);
        else if (core_next) cst <= f_next(cst, core_key);
        if (core_load) n_load <= n_load + 1;
        if (core_next) n_next <= n_next + 1;
        if ((core_load || core_next) && core_busy) n_busy_op <= n_busy_op + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [SK-1:0] k, input logic [SK-1:0] v, output int cyc);
        key = k; iv = v; start = 1'b1;
        tick();
        start = 1'b0; s_valid = 1'b0;
        gst = f_next(f_load(k), v);
        for (int i = 0; i < NW; i++) gst = f_next(gst, '0);
        cyc = 1;
        #1;
        while (!s_ready && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL init_timeout: s_ready=%b after %0d cycles, want 1", s_ready, cyc); end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; start = 1'b1; m_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
            total++; if (m_data !== '0) begin bad++; $display("FAIL rst_m_data: got %h want 0", m_data); end
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
            total++; if (core_load !== 1'b0 || core_next !== 1'b0) begin bad++; $display("FAIL rst_core_ops: got load=%b next=%b want 0 0", core_load, core_next); end
            total++; if (init_ready !== 1'b1) begin bad++; $display("FAIL rst_init_ready: got %b want 1", init_ready); end
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        #1;
        total++; if (init_ready !== 1'b1 || core_load !== 1'b0 || core_next !== 1'b0) begin bad++; $display("FAIL idle_after_rst: got ir=%b load=%b next=%b want 1 0 0", init_ready, core_load, core_next); end
    endtask

    task automatic test_init();
        logic [SK-1:0] k1;
        logic [SK-1:0] v1;
        logic [SK-1:0] want_key;
        k1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        v1 = 128'hFEDCBA9876543210FEDCBA9876543210;
        key = k1; iv = v1; start = 1'b1;
        #1;
        total++; if (init_ready !== 1'b1) begin bad++; $display("FAIL init_ready_idle: got %b want 1", init_ready); end
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
            #1;
            want_key = (c == 1) ? k1 : (c == 2) ? v1 : '0;
            total++; if (core_load !== (c == 1)) begin bad++; $display("FAIL init_load_c%0d: got %b want %b", c, core_load, (c == 1)); end
            total++; if (core_next !== (c >= 2 && c <= 6)) begin bad++; $display("FAIL init_next_c%0d: got %b want %b", c, core_next, (c >= 2 && c <= 6)); end
            total++; if (core_key !== want_key) begin bad++; $display("FAIL init_key_c%0d: got %h want %h", c, core_key, want_key); end
            total++; if (s_ready !== (c == 7)) begin bad++; $display("FAIL init_sready_c%0d: got %b want %b", c, s_ready, (c == 7)); end
        end
        gst = f_next(f_load(k1), v1);
        for (int i = 0; i < NW; i++) gst = f_next(gst, '0);
    endtask

    task automatic test_stream_zero();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = '0;
            #1;
            total++; if (s_ready !== 1'b1 || core_next !== 1'b1) begin bad++; $display("FAIL zero_fire_%0d: got s_ready=%b next=%b want 1 1", i, s_ready, core_next); end
            tick();
            total++; if (m_valid !== 1'b1 || m_data !== f_ks(gst)) begin bad++; $display("FAIL zero_word_%0d: got v=%b d=%h want 1 %h", i, m_valid, m_data, f_ks(gst)); end
            gst = f_next(gst, '0);
        end
        s_valid = 1'b0;
        #1;
        total++; if (core_next !== 1'b0) begin bad++; $display("FAIL zero_idle_next: got %b want 0", core_next); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL zero_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [KS-1:0] w0;
        logic [KS-1:0] w1;
        logic [KS-1:0] hold;
        int            cyc;
        int            nn;
        w0 = 32'hA5A5A5A5;
        w1 = 32'h3C3C0FF0;
        // Restart from STREAM with a plaintext word offered in the same cycle.
        s_valid = 1'b1; s_data = w1; start = 1'b1;
        key = 128'h1111222233334444555566667777AAAA; iv = 128'h9999888877776666555544443333BBBB;
        #1;
        total++; if (s_ready !== 1'b0 || core_next !== 1'b0 || init_ready !== 1'b1) begin bad++; $display("FAIL restart_block: got s_ready=%b next=%b ir=%b want 0 0 1", s_ready, core_next, init_ready); end
        do_init(key, iv, cyc);
        total++; if (cyc !== 7) begin bad++; $display("FAIL restart_latency: got %0d want 7", cyc); end
        m_ready = 1'b0; s_valid = 1'b1; s_data = w0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready: got %b want 1", s_ready); end
        tick();
        s_data = w1;
        hold = w0 ^ f_ks(gst);
        gst = f_next(gst, '0);
        total++; if (m_valid !== 1'b1 || m_data !== hold) begin bad++; $display("FAIL bp_first_word: got v=%b d=%h want 1 %h", m_valid, m_data, hold); end
        nn = n_next;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (s_ready !== 1'b0 || core_next !== 1'b0) begin bad++; $display("FAIL bp_stall_%0d: got s_ready=%b next=%b want 0 0", c, s_ready, core_next); end
            tick();
            total++; if (m_valid !== 1'b1 || m_data !== hold) begin bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h want 1 %h", c, m_valid, m_data, hold); end
        end
        total++; if (n_next !== nn) begin bad++; $display("FAIL bp_no_ops: got %0d nexts want %0d", n_next, nn); end
        m_ready = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", s_ready); end
        tick();
        total++; if (m_valid !== 1'b1 || m_data !== (w1 ^ f_ks(gst))) begin bad++; $display("FAIL bp_resume: got v=%b d=%h want 1 %h", m_valid, m_data, w1 ^ f_ks(gst)); end
        gst = f_next(gst, '0);
        s_valid = 1'b0;
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", m_valid); end
    endtask

    task automatic stream_words(input string tag, input logic [KS-1:0] base, input int n);
        int            idx;
        logic          fired;
        logic [KS-1:0] w;
        idx = 0;
        m_ready = 1'b1;
        for (int t = 0; t < 400 && idx < n; t++) begin
            w = base + KS'(idx * 32'h01010101);
            s_valid = 1'b1; s_data = w;
            #1;
            fired = s_ready;
            tick();
            if (fired) begin
                total++; if (m_valid !== 1'b1 || m_data !== (w ^ f_ks(gst))) begin bad++; $display("FAIL %s_word_%0d: got v=%b d=%h want 1 %h", tag, idx, m_valid, m_data, w ^ f_ks(gst)); end
                gst = f_next(gst, '0);
                idx++;
            end
        end
        s_valid = 1'b0;
        total++; if (idx !== n) begin bad++; $display("FAIL %s_timeout: got %0d words want %0d", tag, idx, n); end
        tick();
        tick();
    endtask

    task automatic test_busy_core();
        int cyc;
        int nl;
        int nn;
        nl = n_load; nn = n_next;
        busy_en = 1'b1;
        do_init(128'hC0FFEE00DEADBEEF0BADF00D12345678, 128'h0000000100000002000000030000ABCD, cyc);
        total++; if (cyc <= 7) begin bad++; $display("FAIL busy_init_stretch: got %0d cycles want >7", cyc); end
        total++; if (n_load - nl !== 1 || n_next - nn !== 1 + NW) begin bad++; $display("FAIL busy_init_ops: got load=%0d next=%0d want 1 %0d", n_load - nl, n_next - nn, 1 + NW); end
        stream_words("busy", 32'h12345678, 5);
        total++; if (n_busy_op !== 0) begin bad++; $display("FAIL busy_op_while_busy: got %0d want 0", n_busy_op); end
        busy_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int nn;
        key = 128'h44444444444444444444444444444444; iv = 128'h55555555555555555555555555555555;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        total++; if (core_next !== 1'b0) begin bad++; $display("FAIL midrst_next_in_rst: got %b want 0", core_next); end
        nn = n_next;
        tick();
        rst = 1'b0;
        #1;
        total++; if (core_next !== 1'b0 || core_load !== 1'b0 || init_ready !== 1'b1) begin bad++; $display("FAIL midrst_after: got next=%b load=%b ir=%b want 0 0 1", core_next, core_load, init_ready); end
        tick(); tick(); tick();
        total++; if (n_next !== nn) begin bad++; $display("FAIL midrst_stale_next: got %0d want %0d", n_next, nn); end
        do_init(128'h6A09E667BB67AE853C6EF372A54FF53A, 128'h510E527F9B05688C1F83D9AB5BE0CD19, cyc);
        stream_words("midrst", 32'hF0E1D2C3, 3);
    endtask

    initial begin
        test_reset();
        test_init();
        test_stream_zero();
        test_backpressure();
        test_busy_core();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
